// File: rtl/spi_dac_stream_writer_if.sv
// Word stream into the DAC write engine: valid/ready with data captured on handshake.
interface spi_dac_stream_writer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/spi_dac_stream_writer.sv
// Serial DAC write engine: queues stream words in a small FIFO and emits one
// CS_N-framed SPI frame per word (SCLK idles high, DAC samples on falling SCLK).
//
// state | meaning
// IDLE  | waiting for a queued word; divider held at 0
// SHIFT | CS_N low, toggling SCLK, presenting one bit per SCLK period
// HOLD  | last bit done, SCLK high, CS_N held low one more half-period
// GAP   | CS_N high for CS_GAP half-periods before the next frame
module spi_dac_stream_writer #(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_GAP     = 1,
  parameter int LSB_FIRST  = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  spi_dac_stream_writer_if.slave              s_if,
  input  logic                                flush,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                dac_cs_n,
  output logic                                dac_sclk,
  output logic                                dac_din
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CS_GAP > 0) ? $clog2(CS_GAP+1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [DATA_W-1:0] head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              s_ready_q;
  logic              push, pop, tick;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              cs_n_d, sclk_d, din_d, done_d;

  assign push       = s_if.s_valid && s_ready_q;
  assign pop        = (state_q == IDLE) && (level_q != '0);
  assign head       = mem[rd_ptr];
  assign tick       = (div_cnt_q == DIV_W'(CLK_DIV-1));
  assign s_if.s_ready = s_ready_q;
  assign fifo_level = level_q;
  assign busy       = (state_q != IDLE);

  // Next FIFO occupancy; flush wins over a same-cycle push.
  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // FIFO pointers, level and ready; ready is registered from the next level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      s_ready_q <= 1'b1;
    end else begin
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      level_q   <= level_d;
      s_ready_q <= (level_d != LVL_W'(FIFO_DEPTH));
    end
  end

  // Word storage; data is captured at push time.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= s_if.s_data;
  end

  // Frame sequencing: next state, divider, shifter and pin values.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    cs_n_d    = dac_cs_n;
    sclk_d    = dac_sclk;
    din_d     = dac_din;
    done_d    = 1'b0;
    div_cnt_d = '0;
    if (state_q != IDLE) div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shreg_d   = head;
          cs_n_d    = 1'b0;
          sclk_d    = 1'b1;
          din_d     = (LSB_FIRST != 0) ? head[0] : head[DATA_W-1];
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (dac_sclk) begin
            sclk_d = 1'b0;
          end else if (bit_cnt_q < BIT_W'(DATA_W-1)) begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (LSB_FIRST != 0) begin
              shreg_d = shreg_q >> 1;
              din_d   = shreg_q[1];
            end else begin
              shreg_d = shreg_q << 1;
              din_d   = shreg_q[DATA_W-2];
            end
          end else begin
            sclk_d  = 1'b1;
            din_d   = 1'b0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n_d = 1'b1;
          done_d = 1'b1;
          if (CS_GAP > 0) begin
            gap_cnt_d = GAP_W'(CS_GAP);
            state_d   = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_q <= GAP_W'(1)) state_d = IDLE;
          else gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any frame with pins at idle levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b1;
      dac_din    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      dac_cs_n   <= cs_n_d;
      dac_sclk   <= sclk_d;
      dac_din    <= din_d;
      frame_done <= done_d;
    end
  end
endmodule

// File: tb/tb_spi_dac_stream_writer.sv
// Directed bench: four engine configurations on a shared clock, a pin monitor
// that measures each frame, and hand-computed expectations.
module tb_spi_dac_stream_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  sv = '0;
  logic [3:0]  fl = '0;
  logic [15:0] sd [4];
  wire  [3:0]  rdy, cs_v, sclk_v, din_v, fd_v, busy_v;
  wire  [2:0]  lvl [4];

  spi_dac_stream_writer_if #(.DATA_W(16)) if0 ();
  spi_dac_stream_writer_if #(.DATA_W(12)) if1 ();
  spi_dac_stream_writer_if #(.DATA_W(16)) if2 ();
  spi_dac_stream_writer_if #(.DATA_W(16)) if3 ();

  assign if0.s_valid = sv[0]; assign if0.s_data = sd[0];       assign rdy[0] = if0.s_ready;
  assign if1.s_valid = sv[1]; assign if1.s_data = sd[1][11:0]; assign rdy[1] = if1.s_ready;
  assign if2.s_valid = sv[2]; assign if2.s_data = sd[2];       assign rdy[2] = if2.s_ready;
  assign if3.s_valid = sv[3]; assign if3.s_data = sd[3];       assign rdy[3] = if3.s_ready;

  spi_dac_stream_writer u0 (
    .clk(clk), .rst_n(rst_n), .s_if(if0), .flush(fl[0]), .fifo_level(lvl[0]),
    .busy(busy_v[0]), .frame_done(fd_v[0]), .dac_cs_n(cs_v[0]), .dac_sclk(sclk_v[0]), .dac_din(din_v[0]));
  spi_dac_stream_writer #(.DATA_W(12), .CLK_DIV(3), .LSB_FIRST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .s_if(if1), .flush(fl[1]), .fifo_level(lvl[1]),
    .busy(busy_v[1]), .frame_done(fd_v[1]), .dac_cs_n(cs_v[1]), .dac_sclk(sclk_v[1]), .dac_din(din_v[1]));
  spi_dac_stream_writer #(.CS_GAP(0)) u2 (
    .clk(clk), .rst_n(rst_n), .s_if(if2), .flush(fl[2]), .fifo_level(lvl[2]),
    .busy(busy_v[2]), .frame_done(fd_v[2]), .dac_cs_n(cs_v[2]), .dac_sclk(sclk_v[2]), .dac_din(din_v[2]));
  spi_dac_stream_writer #(.CS_GAP(4)) u3 (
    .clk(clk), .rst_n(rst_n), .s_if(if3), .flush(fl[3]), .fifo_level(lvl[3]),
    .busy(busy_v[3]), .frame_done(fd_v[3]), .dac_cs_n(cs_v[3]), .dac_sclk(sclk_v[3]), .dac_din(din_v[3]));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pin monitor state per instance
  int cyc = 0;
  int low_len[4], last_low_len[4], falls[4], last_falls[4], frames[4], fd_cnt[4], viol[4];
  int high_len[4], last_high_len[4], fall_cyc[4], last_spacing[4];
  logic [31:0] bits[4], last_bits[4];
  logic prev_cs[4], prev_sclk[4];
  logic [31:0] q_words[$];
  int q_spc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Measure CS_N low time, SCLK falling edges, sampled bits, gaps and protocol violations.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        prev_cs[i]   <= 1'b1;
        prev_sclk[i] <= 1'b1;
      end else begin
        if (cs_v[i] == 1'b0) begin
          if (prev_cs[i] == 1'b1) begin
            low_len[i]       <= 1;
            falls[i]         <= 0;
            bits[i]          <= '0;
            last_high_len[i] <= high_len[i];
            last_spacing[i]  <= cyc - fall_cyc[i];
            fall_cyc[i]      <= cyc;
            if (i == 0) q_spc.push_back(cyc - fall_cyc[i]);
          end else begin
            low_len[i] <= low_len[i] + 1;
            if (prev_sclk[i] == 1'b1 && sclk_v[i] == 1'b0) begin
              falls[i] <= falls[i] + 1;
              bits[i]  <= {bits[i][30:0], din_v[i]};
            end
          end
        end else begin
          if (sclk_v[i] == 1'b0) viol[i] <= viol[i] + 1;
          if (prev_cs[i] == 1'b0) begin
            last_low_len[i] <= low_len[i];
            last_falls[i]   <= falls[i];
            last_bits[i]    <= bits[i];
            frames[i]       <= frames[i] + 1;
            high_len[i]     <= 1;
            if (fd_v[i] != 1'b1 || din_v[i] != 1'b0) viol[i] <= viol[i] + 1;
            if (i == 0) q_words.push_back(bits[i]);
          end else begin
            high_len[i] <= high_len[i] + 1;
          end
        end
        if (fd_v[i]) fd_cnt[i] <= fd_cnt[i] + 1;
        prev_cs[i]   <= cs_v[i];
        prev_sclk[i] <= sclk_v[i];
      end
    end
  end

  task automatic push(input int i, input logic [15:0] d);
    int g = 0;
    @(negedge clk);
    sv[i] = 1'b1;
    sd[i] = d;
    while (!rdy[i] && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) chk("push_timeout", 32'(rdy[i]), 1);
    @(negedge clk);
    sv[i] = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int target, input int budget);
    int g = 0;
    while (frames[i] < target && g < budget) begin
      @(posedge clk);
      g++;
    end
    if (frames[i] < target) chk("frame_timeout", 32'(frames[i]), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bw [6];
    int base, k, g, maxl, stall, stall_lvl;
    bw[0] = 16'h1F2E; bw[1] = 16'h3D4C; bw[2] = 16'h5B6A;
    bw[3] = 16'h7988; bw[4] = 16'h97A6; bw[5] = 16'hB5C4;
    for (int i = 0; i < 4; i++) sd[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_v[0]), 1);
    chk("rst_sclk", 32'(sclk_v[0]), 1);
    chk("rst_din", 32'(din_v[0]), 0);
    chk("rst_fd", 32'(fd_v[0]), 0);
    chk("rst_busy", 32'(busy_v[0]), 0);
    chk("rst_level", 32'(lvl[0]), 0);
    chk("rst_ready", 32'(rdy[0]), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word, MSB first, 16 bits, CLK_DIV 2
    push(0, 16'hA5C3);
    wait_frames(0, 1, 400);
    chk("t1_cs_low", 32'(last_low_len[0]), 66);
    chk("t1_falls", 32'(last_falls[0]), 16);
    chk("t1_bits", last_bits[0][15:0], 16'hA5C3);
    chk("t1_fd_cnt", 32'(fd_cnt[0]), 1);
    chk("t1_din_after", 32'(din_v[0]), 0);
    chk("t1_viol", 32'(viol[0]), 0);

    // Burst of 6 with s_valid held
    repeat (5) @(posedge clk);
    q_words.delete();
    q_spc.delete();
    base = frames[0];
    k = 0; g = 0; maxl = 0; stall = 0; stall_lvl = -1;
    while (k < 6 && g < 1000) begin
      @(negedge clk);
      g++;
      sv[0] = 1'b1;
      sd[0] = bw[k];
      if (int'(lvl[0]) > maxl) maxl = int'(lvl[0]);
      if (!rdy[0]) begin
        if (stall == 0) stall_lvl = int'(lvl[0]);
        stall++;
      end else begin
        k++;
      end
    end
    @(negedge clk);
    sv[0] = 1'b0;
    chk("t2_pushed", 32'(k), 6);
    chk("t2_stalled", 32'(stall > 0), 1);
    chk("t2_stall_lvl", 32'(stall_lvl), 4);
    chk("t2_max_lvl", 32'(maxl), 4);
    wait_frames(0, base + 6, 1000);
    chk("t2_nframes", 32'(q_words.size()), 6);
    for (int j = 0; j < 6; j++)
      if (j < q_words.size()) chk($sformatf("t2_word%0d", j), q_words[j][15:0], bw[j]);
    for (int j = 1; j < 6; j++)
      if (j < q_spc.size()) chk($sformatf("t2_spacing%0d", j), 32'(q_spc[j]), 69);
    chk("t2_fd_cnt", 32'(fd_cnt[0]), 32'(frames[0]));

    // LSB first, 12 bits, CLK_DIV 3
    push(1, 16'h0801);
    wait_frames(1, 1, 400);
    chk("t3_bits_801", last_bits[1][11:0], 12'h801);
    chk("t3_cs_low", 32'(last_low_len[1]), 75);
    chk("t3_falls", 32'(last_falls[1]), 12);
    push(1, 16'h00A3);
    wait_frames(1, 2, 400);
    chk("t3_bits_0a3", last_bits[1][11:0], 12'hC50);
    chk("t3_viol", 32'(viol[1]), 0);

    // Inter-frame CS_N gap, CS_GAP 0 and 4
    push(2, 16'h1111);
    push(2, 16'h2222);
    push(3, 16'h3333);
    push(3, 16'h4444);
    wait_frames(2, 2, 400);
    wait_frames(3, 2, 400);
    chk("t4_gap0_high", 32'(last_high_len[2]), 1);
    chk("t4_gap0_spacing", 32'(last_spacing[2]), 67);
    chk("t4_gap4_high", 32'(last_high_len[3]), 9);
    chk("t4_gap4_spacing", 32'(last_spacing[3]), 75);
    chk("t4_gap4_word2", last_bits[3][15:0], 16'h4444);
    chk("t4_viol", 32'(viol[2] + viol[3]), 0);

    // Flush during frame 1
    repeat (5) @(posedge clk);
    base = frames[0];
    push(0, 16'hBEEF);
    push(0, 16'h1357);
    push(0, 16'h2468);
    chk("t5_lvl_pre", 32'(lvl[0]), 2);
    repeat (20) @(negedge clk);
    fl[0] = 1'b1;
    @(negedge clk);
    fl[0] = 1'b0;
    chk("t5_lvl_flush", 32'(lvl[0]), 0);
    chk("t5_busy_mid", 32'(busy_v[0]), 1);
    wait_frames(0, base + 1, 200);
    chk("t5_bits", last_bits[0][15:0], 16'hBEEF);
    chk("t5_cs_low", 32'(last_low_len[0]), 66);
    repeat (300) @(posedge clk);
    chk("t5_no_more", 32'(frames[0]), 32'(base + 1));
    chk("t5_busy_end", 32'(busy_v[0]), 0);

    // Flush coincident with push
    @(negedge clk);
    sv[0] = 1'b1; sd[0] = 16'h7777; fl[0] = 1'b1;
    @(negedge clk);
    sv[0] = 1'b0; fl[0] = 1'b0;
    chk("t6_lvl", 32'(lvl[0]), 0);
    chk("t6_ready", 32'(rdy[0]), 1);
    repeat (50) @(posedge clk);
    chk("t6_no_frame", 32'(frames[0]), 32'(base + 1));
    chk("t6_busy", 32'(busy_v[0]), 0);

    // Reset mid-frame at bit 7
    base = frames[0];
    push(0, 16'h1234);
    g = 0;
    while (cs_v[0] != 1'b0 && g < 100) begin @(posedge clk); g++; end
    repeat (2) @(negedge clk);
    while (falls[0] < 7 && g < 300) begin @(posedge clk); g++; end
    if (g >= 300) chk("t7_reach_bit7", 32'(falls[0]), 7);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_cs_n", 32'(cs_v[0]), 1);
    chk("t7_sclk", 32'(sclk_v[0]), 1);
    chk("t7_din", 32'(din_v[0]), 0);
    chk("t7_level", 32'(lvl[0]), 0);
    chk("t7_busy", 32'(busy_v[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(0, 16'h3C96);
    wait_frames(0, base + 1, 300);
    chk("t7_bits", last_bits[0][15:0], 16'h3C96);
    chk("t7_cs_low", 32'(last_low_len[0]), 66);
    chk("t7_falls", 32'(last_falls[0]), 16);
    chk("t7_viol", 32'(viol[0]), 0);
    chk("t7_fd_cnt", 32'(fd_cnt[0]), 32'(frames[0]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
